// File: rtl/ovc_status_if.sv
//==============================================================================
// Module      : ovc_status_if
// Description : Event and status bundle between VC/switch allocation and the
//               per-output-VC status tracker.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ovc_status_if #(
  parameter int PORT_NUM        = 4,
  parameter int VC_NUM_PER_PORT = 4
);
  localparam int PV = PORT_NUM * VC_NUM_PER_PORT;

  logic [PV-1:0]       flit_sent_vec;
  logic [PV-1:0]       credit_in_vec;
  logic [PV-1:0]       ovc_alloc_vec;
  logic [PV-1:0]       ovc_release_vec;
  logic [PV-1:0]       credit_avb;
  logic [PV-1:0]       full_credit;
  logic [PV-1:0]       ovc_avb;
  logic [PORT_NUM-1:0] port_ovc_avb;
  logic                err;

  modport master (
    output flit_sent_vec, credit_in_vec, ovc_alloc_vec, ovc_release_vec,
    input  credit_avb, full_credit, ovc_avb, port_ovc_avb, err
  );

  modport slave (
    input  flit_sent_vec, credit_in_vec, ovc_alloc_vec, ovc_release_vec,
    output credit_avb, full_credit, ovc_avb, port_ovc_avb, err
  );
endinterface

`default_nettype wire

// File: rtl/ovc_status.sv
//==============================================================================
// Module      : ovc_status
// Description : Per-output-VC credit counter and FREE/BUSY tracker with flat,
//               port-major status vectors. Optional macro OVC_ATOMIC_EN makes
//               a VC allocatable only once its downstream buffer has drained.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ovc_status #(
  parameter int PORT_NUM        = 4,
  parameter int VC_NUM_PER_PORT = 4,
  parameter int BUFFER_DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  ovc_status_if.slave   bus
);
  localparam int PV = PORT_NUM * VC_NUM_PER_PORT;
  localparam int CW = $clog2(BUFFER_DEPTH + 1);

  localparam logic [CW-1:0] C_FULL_CREDIT = CW'(BUFFER_DEPTH);
  localparam logic [CW-1:0] C_ZERO_CREDIT = '0;

  localparam logic [0:0] ST_FREE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [PV-1:0] w_credit_avb;
  logic [PV-1:0] w_full_credit;
  logic [PV-1:0] w_ovc_avb;
  logic [PV-1:0] w_err_vec;
  logic          r_err;

  for (genvar i = 0; i < PV; i++) begin : g_vc
    logic [CW-1:0] r_credit;
    logic [0:0]    r_state;
    logic          w_sent;
    logic          w_cin;
    logic          w_alloc;
    logic          w_rel;
    logic          w_busy;
    logic          w_underflow;
    logic          w_overflow;
    logic          w_alloc_err;

    assign w_sent  = bus.flit_sent_vec[i];
    assign w_cin   = bus.credit_in_vec[i];
    assign w_alloc = bus.ovc_alloc_vec[i];
    assign w_rel   = bus.ovc_release_vec[i];
    assign w_busy  = (r_state == ST_BUSY);

    assign w_underflow = w_sent & ~w_cin & (r_credit == C_ZERO_CREDIT);
    assign w_overflow  = w_cin & ~w_sent & (r_credit == C_FULL_CREDIT);
    // Alloc wins over release, so any alloc on a busy VC or paired with a
    // release is an error, as is a release on a free VC.
    assign w_alloc_err = (w_alloc & (w_busy | w_rel)) | (w_rel & ~w_busy);

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_credit <= C_FULL_CREDIT;
      end else if (w_sent && !w_cin && !w_underflow) begin
        r_credit <= r_credit - 1'b1;
      end else if (w_cin && !w_sent && !w_overflow) begin
        r_credit <= r_credit + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        r_state <= ST_FREE;
      end else begin
        case (r_state)
          ST_FREE: if (w_alloc) r_state <= ST_BUSY;
          ST_BUSY: if (w_rel && !w_alloc) r_state <= ST_FREE;
          default: r_state <= ST_FREE;
        endcase
      end
    end

    assign w_credit_avb[i]  = (r_credit != C_ZERO_CREDIT);
    assign w_full_credit[i] = (r_credit == C_FULL_CREDIT);
    assign w_err_vec[i]     = w_underflow | w_overflow | w_alloc_err;

`ifdef OVC_ATOMIC_EN
    assign w_ovc_avb[i] = ~w_busy & w_full_credit[i];
`else
    assign w_ovc_avb[i] = ~w_busy;
`endif
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
    assign bus.port_ovc_avb[p] =
      |w_ovc_avb[(p+1)*VC_NUM_PER_PORT-1 -: VC_NUM_PER_PORT];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (|w_err_vec) begin
      r_err <= 1'b1;
    end
  end

  assign bus.credit_avb  = w_credit_avb;
  assign bus.full_credit = w_full_credit;
  assign bus.ovc_avb     = w_ovc_avb;
  assign bus.err         = r_err;

endmodule

`default_nettype wire
